// File: rtl/interval_lfsr_fifo_if.sv
// Interval stream handshake between the LFSR interval source (master) and the blink stage (slave).
interface interval_lfsr_fifo_if #(
  parameter int INTERVAL_WIDTH = 4
);
  logic [INTERVAL_WIDTH-1:0] interval_out;
  logic                      interval_valid;
  logic                      interval_ready;

  modport master (
    output interval_out,
    output interval_valid,
    input  interval_ready
  );

  modport slave (
    input  interval_out,
    input  interval_valid,
    output interval_ready
  );
endinterface

// File: rtl/interval_lfsr_fifo.sv
// LFSR interval source: samples low LFSR bits every SHIFTS_PER_SAMPLE shifts into a FWFT FIFO.
// Push-to-visible latency 1 cycle; when full without a same-edge pop, candidates are dropped and counted.
module interval_lfsr_fifo #(
  parameter int                    LFSR_WIDTH        = 8,
  parameter logic [LFSR_WIDTH-1:0] SEED              = 8'h01,
  parameter int                    SHIFTS_PER_SAMPLE = 8,
  parameter int                    INTERVAL_WIDTH    = 4,
  parameter int                    MIN_INTERVAL      = 1,
  parameter int                    FIFO_DEPTH        = 4
) (
  input  logic                          clk_edge,
  input  logic                          rstbtn,
  input  logic                          enable,
  interval_lfsr_fifo_if.master          ivl,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          reject_pulse,
  output logic                          drop_pulse,
  output logic [7:0]                    drop_count,
  output logic [LFSR_WIDTH-1:0]         lfsr_state
);

  localparam int                 PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [7:0]         CNT_LAST = 8'(SHIFTS_PER_SAMPLE - 1);
  localparam logic [PTR_W:0]     FULL_LVL = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [31:0]        MIN_U    = 32'(MIN_INTERVAL);

  logic [LFSR_WIDTH-1:0]     r_lfsr;
  logic [7:0]                r_cnt;
  logic [INTERVAL_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          r_wr_ptr;
  logic [PTR_W-1:0]          r_rd_ptr;
  logic [PTR_W:0]            r_fill;
  logic                      r_reject;
  logic                      r_drop;
  logic [7:0]                r_drop_cnt;

  logic                      w_fb;
  logic [LFSR_WIDTH-1:0]     w_lfsr_next;
  logic                      w_sample;
  logic [INTERVAL_WIDTH-1:0] w_cand;
  logic                      w_below;
  logic                      w_not_empty;
  logic                      w_full;
  logic                      w_pop;
  logic                      w_push;
  logic                      w_drop;

  // Taps x^8+x^6+x^5+x^4+1; only meaningful for an 8-bit register.
  assign w_fb        = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_lfsr_next = {r_lfsr[LFSR_WIDTH-2:0], w_fb};

  // The candidate comes from the post-shift state, so it is visible in lfsr_state after the edge.
  assign w_sample    = enable && (r_cnt == CNT_LAST);
  assign w_cand      = w_lfsr_next[INTERVAL_WIDTH-1:0];
  assign w_below     = (32'(w_cand) < MIN_U);

  assign w_not_empty = (r_fill != '0);
  assign w_full      = (r_fill == FULL_LVL);
  assign w_pop       = w_not_empty && ivl.interval_ready;
  assign w_push      = w_sample && !w_below && (!w_full || w_pop);
  assign w_drop      = w_sample && !w_below && w_full && !w_pop;

  always_ff @(posedge clk_edge or posedge rstbtn) begin
    if (rstbtn) begin
      r_lfsr <= SEED;
      r_cnt  <= '0;
    end else if (enable) begin
      r_lfsr <= w_lfsr_next;
      r_cnt  <= (r_cnt == CNT_LAST) ? 8'd0 : r_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_edge or posedge rstbtn) begin
    if (rstbtn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_cand;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end

  always_ff @(posedge clk_edge or posedge rstbtn) begin
    if (rstbtn) begin
      r_reject   <= 1'b0;
      r_drop     <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_reject <= w_sample && w_below;
      r_drop   <= w_drop;
      if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  // Head is masked to zero when empty so a stale entry is never presented.
  assign ivl.interval_out   = w_not_empty ? r_mem[r_rd_ptr] : '0;
  assign ivl.interval_valid = w_not_empty;
  assign fill_level         = r_fill;
  assign reject_pulse       = r_reject;
  assign drop_pulse         = r_drop;
  assign drop_count         = r_drop_cnt;
  assign lfsr_state         = r_lfsr;

  a_fill_bound: assert property (@(posedge clk_edge) disable iff (rstbtn) r_fill <= FULL_LVL);
  a_no_overrun: assert property (@(posedge clk_edge) disable iff (rstbtn) !(w_push && w_full && !w_pop));

endmodule

// File: tb/tb_interval_lfsr_fifo.sv
// Directed bench for interval_lfsr_fifo; a second instance with MIN_INTERVAL=13 covers rejection.
module tb_interval_lfsr_fifo;

  logic       clk_edge = 1'b0;
  logic       rstbtn   = 1'b0;
  logic       enable   = 1'b0;
  logic [2:0] fill1, fill2;
  logic       rej1, rej2, drp1, drp2;
  logic [7:0] dcnt1, dcnt2, lfsr1, lfsr2;
  int         checks = 0;
  int         errors = 0;

  interval_lfsr_fifo_if #(.INTERVAL_WIDTH(4)) if1 ();
  interval_lfsr_fifo_if #(.INTERVAL_WIDTH(4)) if2 ();

  interval_lfsr_fifo u_dut (
    .clk_edge(clk_edge), .rstbtn(rstbtn), .enable(enable), .ivl(if1.master),
    .fill_level(fill1), .reject_pulse(rej1), .drop_pulse(drp1),
    .drop_count(dcnt1), .lfsr_state(lfsr1)
  );

  interval_lfsr_fifo #(.MIN_INTERVAL(13)) u_dut13 (
    .clk_edge(clk_edge), .rstbtn(rstbtn), .enable(enable), .ivl(if2.master),
    .fill_level(fill2), .reject_pulse(rej2), .drop_pulse(drp2),
    .drop_count(dcnt2), .lfsr_state(lfsr2)
  );

  always #5 clk_edge = ~clk_edge;

  task automatic step();
    @(posedge clk_edge);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Reset across two negedges; the next posedge after return is enabled edge 1.
  task automatic do_reset(input logic en);
    @(negedge clk_edge);
    rstbtn = 1'b1;
    enable = 1'b0;
    if1.interval_ready = 1'b0;
    if2.interval_ready = 1'b0;
    @(negedge clk_edge);
    @(negedge clk_edge);
    rstbtn = 1'b0;
    enable = en;
  endtask

  task automatic test_reset();
    #2;
    rstbtn = 1'b1;
    #1;
    checks++;
    if (lfsr1 !== 8'h01 || fill1 !== 3'd0 || if1.interval_valid !== 1'b0 || if1.interval_out !== 4'h0 ||
        rej1 !== 1'b0 || drp1 !== 1'b0 || dcnt1 !== 8'd0) begin
      errors++;
      $display("FAIL reset_async: lfsr=%h fill=%0d valid=%b out=%h rej=%b drp=%b dcnt=%0d, want 01 0 0 0 0 0 0",
               lfsr1, fill1, if1.interval_valid, if1.interval_out, rej1, drp1, dcnt1);
    end
  endtask

  task automatic test_enable_hold();
    do_reset(1'b0);
    steps(3);
    checks++;
    if (lfsr1 !== 8'h01) begin errors++; $display("FAIL enable_hold: lfsr=%h want 01", lfsr1); end
    enable = 1'b1;
    step();
    checks++;
    if (lfsr1 !== 8'h02) begin errors++; $display("FAIL first_shift: lfsr=%h want 02", lfsr1); end
    steps(3);
    checks++;
    if (lfsr1 !== 8'h11) begin errors++; $display("FAIL shift4: lfsr=%h want 11", lfsr1); end
  endtask

  task automatic test_first_fill();
    do_reset(1'b1);
    steps(7);
    checks++;
    if (if1.interval_valid !== 1'b0) begin errors++; $display("FAIL fill_pre8: valid=%b want 0", if1.interval_valid); end
    step();
    checks++;
    if (if1.interval_valid !== 1'b1 || if1.interval_out !== 4'hC || fill1 !== 3'd1 || lfsr1 !== 8'h1C || rej1 !== 1'b0) begin
      errors++;
      $display("FAIL fill_edge8: valid=%b out=%h fill=%0d lfsr=%h rej=%b want 1 c 1 1c 0",
               if1.interval_valid, if1.interval_out, fill1, lfsr1, rej1);
    end
    steps(8);
    checks++;
    if (fill1 !== 3'd2 || if1.interval_out !== 4'hC || lfsr1 !== 8'h4B) begin
      errors++;
      $display("FAIL fill_edge16: fill=%0d out=%h lfsr=%h want 2 c 4b", fill1, if1.interval_out, lfsr1);
    end
  endtask

  task automatic test_rejection();
    do_reset(1'b1);
    steps(8);
    checks++;
    if (rej2 !== 1'b1 || if2.interval_valid !== 1'b0) begin
      errors++; $display("FAIL reject_edge8: rej=%b valid=%b want 1 0", rej2, if2.interval_valid);
    end
    step();
    checks++;
    if (rej2 !== 1'b0) begin errors++; $display("FAIL reject_width: rej=%b want 0", rej2); end
    steps(7);
    checks++;
    if (rej2 !== 1'b1 || if2.interval_valid !== 1'b0) begin
      errors++; $display("FAIL reject_edge16: rej=%b valid=%b want 1 0", rej2, if2.interval_valid);
    end
    steps(16);
    checks++;
    if (rej2 !== 1'b1 || if2.interval_valid !== 1'b0 || fill2 !== 3'd0) begin
      errors++; $display("FAIL reject_edge32: rej=%b valid=%b fill=%0d want 1 0 0", rej2, if2.interval_valid, fill2);
    end
    steps(8);
    checks++;
    if (rej2 !== 1'b0 || if2.interval_valid !== 1'b1 || if2.interval_out !== 4'hE || fill2 !== 3'd1) begin
      errors++;
      $display("FAIL accept_edge40: rej=%b valid=%b out=%h fill=%0d want 0 1 e 1",
               rej2, if2.interval_valid, if2.interval_out, fill2);
    end
  endtask

  task automatic test_overflow();
    int pulses = 0;
    do_reset(1'b1);
    for (int cyc = 1; cyc <= 200; cyc++) begin
      step();
      if (drp1 === 1'b1) pulses++;
      if (cyc == 40) begin
        checks++;
        if (drp1 !== 1'b1 || dcnt1 !== 8'd1) begin
          errors++; $display("FAIL first_drop: drp=%b dcnt=%0d want 1 1", drp1, dcnt1);
        end
      end
    end
    checks++;
    if (fill1 !== 3'd4 || if1.interval_out !== 4'hC || if1.interval_valid !== 1'b1) begin
      errors++;
      $display("FAIL overflow_state: fill=%0d out=%h valid=%b want 4 c 1", fill1, if1.interval_out, if1.interval_valid);
    end
    checks++;
    if (dcnt1 !== 8'(pulses) || pulses < 15) begin
      errors++; $display("FAIL drop_count: dcnt=%0d pulses=%0d want equal and >=15", dcnt1, pulses);
    end
  endtask

  task automatic test_saturation();
    do_reset(1'b1);
    steps(2400);
    checks++;
    if (dcnt1 !== 8'd255) begin errors++; $display("FAIL drop_saturate: dcnt=%0d want 255", dcnt1); end
  endtask

  task automatic test_streaming();
    do_reset(1'b1);
    if1.interval_ready = 1'b1;
    steps(8);
    checks++;
    if (if1.interval_valid !== 1'b1 || if1.interval_out !== 4'hC || fill1 !== 3'd1) begin
      errors++;
      $display("FAIL stream_first: valid=%b out=%h fill=%0d want 1 c 1", if1.interval_valid, if1.interval_out, fill1);
    end
    step();
    checks++;
    if (if1.interval_valid !== 1'b0 || if1.interval_out !== 4'h0 || fill1 !== 3'd0) begin
      errors++;
      $display("FAIL stream_pop: valid=%b out=%h fill=%0d want 0 0 0", if1.interval_valid, if1.interval_out, fill1);
    end
    steps(7);
    checks++;
    if (if1.interval_valid !== 1'b1 || if1.interval_out !== 4'hB || fill1 !== 3'd1) begin
      errors++;
      $display("FAIL stream_second: valid=%b out=%h fill=%0d want 1 b 1", if1.interval_valid, if1.interval_out, fill1);
    end
    step();
    checks++;
    if (if1.interval_valid !== 1'b0 || fill1 !== 3'd0) begin
      errors++; $display("FAIL stream_pop2: valid=%b fill=%0d want 0 0", if1.interval_valid, fill1);
    end
    if1.interval_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    do_reset(1'b1);
    steps(39);
    checks++;
    if (fill1 !== 3'd4 || if1.interval_out !== 4'hC) begin
      errors++; $display("FAIL pp_prefill: fill=%0d out=%h want 4 c", fill1, if1.interval_out);
    end
    if1.interval_ready = 1'b1;
    step();
    if1.interval_ready = 1'b0;
    checks++;
    if (fill1 !== 3'd4 || drp1 !== 1'b0 || dcnt1 !== 8'd0 || if1.interval_out !== 4'hB) begin
      errors++;
      $display("FAIL pp_edge40: fill=%0d drp=%b dcnt=%0d out=%h want 4 0 0 b", fill1, drp1, dcnt1, if1.interval_out);
    end
    if1.interval_ready = 1'b1;
    steps(3);
    if1.interval_ready = 1'b0;
    checks++;
    if (if1.interval_out !== 4'hE || fill1 !== 3'd1) begin
      errors++; $display("FAIL pp_tail: out=%h fill=%0d want e 1", if1.interval_out, fill1);
    end
  endtask

  task automatic test_mid_reset();
    do_reset(1'b1);
    steps(40);
    if1.interval_ready = 1'b1;
    step();
    if1.interval_ready = 1'b0;
    checks++;
    if (fill1 !== 3'd3 || dcnt1 !== 8'd1) begin
      errors++; $display("FAIL mid_pre: fill=%0d dcnt=%0d want 3 1", fill1, dcnt1);
    end
    #2;
    rstbtn = 1'b1;
    #1;
    checks++;
    if (if1.interval_valid !== 1'b0 || fill1 !== 3'd0 || dcnt1 !== 8'd0 || lfsr1 !== 8'h01 || if1.interval_out !== 4'h0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b fill=%0d dcnt=%0d lfsr=%h out=%h want 0 0 0 01 0",
               if1.interval_valid, fill1, dcnt1, lfsr1, if1.interval_out);
    end
    @(negedge clk_edge);
    rstbtn = 1'b0;
    steps(8);
    checks++;
    if (if1.interval_valid !== 1'b1 || if1.interval_out !== 4'hC || fill1 !== 3'd1) begin
      errors++;
      $display("FAIL mid_restart: valid=%b out=%h fill=%0d want 1 c 1", if1.interval_valid, if1.interval_out, fill1);
    end
  endtask

  initial begin
    if1.interval_ready = 1'b0;
    if2.interval_ready = 1'b0;
    test_reset();
    test_enable_hold();
    test_first_fill();
    test_rejection();
    test_overflow();
    test_saturation();
    test_streaming();
    test_full_push_pop();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
